// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input path: default widths and direction encoding.
package gpio_pkg;
  localparam int GPIO_WIDTH       = 16;
  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_DEB_W       = 4;

  localparam logic GPIO_DIR_IN  = 1'b0;
  localparam logic GPIO_DIR_OUT = 1'b1;
endpackage

// File: rtl/gpio_input_irq_if.sv
// Bus bundle between the register interface (master) and the GPIO input/IRQ block (slave).
interface gpio_input_irq_if
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter int DEB_W = GPIO_DEB_W
);
  logic [WIDTH-1:0] gpio_data_in;
  logic [WIDTH-1:0] gpio_dir;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_rise_en;
  logic [WIDTH-1:0] irq_fall_en;
  logic [WIDTH-1:0] irq_clr;
  logic [DEB_W-1:0] deb_limit;
  logic [WIDTH-1:0] data_stable;
  logic [WIDTH-1:0] irq_status;
  logic             irq;

  modport master (
    output gpio_data_in, gpio_dir, irq_en, irq_rise_en, irq_fall_en, irq_clr, deb_limit,
    input  data_stable, irq_status, irq
  );

  modport slave (
    input  gpio_data_in, gpio_dir, irq_en, irq_rise_en, irq_fall_en, irq_clr, deb_limit,
    output data_stable, irq_status, irq
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: synchronizer, debounce counter (only when GPIO_DEBOUNCE_EN is defined), edge detect.
// Without GPIO_DEBOUNCE_EN the stable value is the synchronized input registered once.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DEB_W       = GPIO_DEB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_din,
  input  logic             i_dir,
  input  logic [DEB_W-1:0] i_deb_limit,
  output logic             o_stable,
  output logic             o_rise,
  output logic             o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;
  logic                   w_stable_nxt;
  logic                   w_is_in;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_is_in = (i_dir == GPIO_DIR_IN);

  // Metastability synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] CNT_MAX  = {DEB_W{1'b1}};
  localparam logic [DEB_W-1:0] CNT_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] CNT_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

  logic [DEB_W-1:0] r_cnt;
  logic [DEB_W-1:0] w_cnt_nxt;

  // Debounce: >= so that lowering the limit mid-count takes effect on the next mismatch
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    if (!w_is_in) begin
      w_cnt_nxt    = CNT_ZERO;
      w_stable_nxt = 1'b0;
    end else if (w_sync != r_stable) begin
      if (r_cnt >= i_deb_limit) begin
        w_cnt_nxt    = CNT_ZERO;
        w_stable_nxt = w_sync;
      end else if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_cnt_nxt = CNT_ZERO;
    end
  end

  // Debounce counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  logic w_unused_limit;
  assign w_unused_limit = ^i_deb_limit;

  // Pass-through path: stable value is the synchronized input, forced low on output bits
  always_comb begin
    w_stable_nxt = 1'b0;
    if (w_is_in) begin
      w_stable_nxt = w_sync;
    end else begin
      w_stable_nxt = 1'b0;
    end
  end
`endif

  // Stable value and registered edges; the forced drop on output bits is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_stable <= w_stable_nxt;
      r_rise   <= w_is_in & w_stable_nxt & ~r_stable;
      r_fall   <= w_is_in & ~w_stable_nxt & r_stable;
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/gpio_input_irq.sv
// GPIO input path top: per-bit debounce/edge detect, sticky interrupt status, irq reduction.
// Optional macro GPIO_DEBOUNCE_EN enables the per-bit debounce counters.
module gpio_input_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DEB_W       = GPIO_DEB_W
) (
  input  logic           clk,
  input  logic           rst_n,
  gpio_input_irq_if.slave bus
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] r_status;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
    ) u_bit (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_din       (bus.gpio_data_in[g]),
      .i_dir       (bus.gpio_dir[g]),
      .i_deb_limit (bus.deb_limit),
      .o_stable    (w_stable[g]),
      .o_rise      (w_rise[g]),
      .o_fall      (w_fall[g])
    );
  end

  assign w_set = bus.irq_en & ~bus.gpio_dir &
                 ((w_rise & bus.irq_rise_en) | (w_fall & bus.irq_fall_en));

  // Sticky status: set has priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= {WIDTH{1'b0}};
    end else begin
      r_status <= (r_status & ~bus.irq_clr) | w_set;
    end
  end

  assign bus.data_stable = w_stable;
  assign bus.irq_status  = r_status;
  assign bus.irq         = |(r_status & bus.irq_en);

endmodule

// File: tb/tb_gpio_input_irq.sv
// Directed self-checking bench for gpio_input_irq; adapts latency to GPIO_DEBOUNCE_EN.
module tb_gpio_input_irq;
  localparam int SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int          LEFF = 3;
  localparam logic [3:0]  DEB  = 4'd3;
`else
  localparam int          LEFF = 0;
  localparam logic [3:0]  DEB  = 4'hF;
`endif
  localparam int LAT = SYNC + LEFF + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gpio_input_irq_if #(.WIDTH(16), .DEB_W(4)) bus ();

  gpio_input_irq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus.irq_clr = 16'hFFFF;
    tick(1);
    bus.irq_clr = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.gpio_data_in = 16'h0000; bus.gpio_dir = 16'h0000; bus.irq_en = 16'hFFFF;
    bus.irq_rise_en = 16'hFFFF; bus.irq_fall_en = 16'h0000; bus.irq_clr = 16'h0000;
    bus.deb_limit = DEB;
    tick(2);
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL reset_stable got=%h exp=%h", bus.data_stable, 16'h0000); end
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=%h", bus.irq_status, 16'h0000); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_rise();
    bus.gpio_data_in = 16'h0001;
    tick(LAT - 1);
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL rise_early got=%h exp=%h", bus.data_stable, 16'h0000); end
    tick(1);
    checks++; if (bus.data_stable !== 16'h0001) begin failures++; $display("FAIL rise_stable got=%h exp=%h", bus.data_stable, 16'h0001); end
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL rise_status_early got=%h exp=%h", bus.irq_status, 16'h0000); end
    tick(1);
    checks++; if (bus.irq_status !== 16'h0001) begin failures++; $display("FAIL rise_status got=%h exp=%h", bus.irq_status, 16'h0001); end
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL rise_irq got=%b exp=1", bus.irq); end
    bus.irq_en = 16'h0000;
    #1;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", bus.irq); end
    tick(1);
    checks++; if (bus.irq_status !== 16'h0001) begin failures++; $display("FAIL mask_keeps_status got=%h exp=%h", bus.irq_status, 16'h0001); end
    bus.irq_en = 16'hFFFF;
    bus.irq_clr = 16'h0001;
    tick(1);
    bus.irq_clr = 16'h0000;
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL clear got=%h exp=%h", bus.irq_status, 16'h0000); end
    bus.gpio_data_in = 16'h0000;
    tick(LAT + 2);
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL fall_stable got=%h exp=%h", bus.data_stable, 16'h0000); end
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL fall_not_selected got=%h exp=%h", bus.irq_status, 16'h0000); end
  endtask

  task automatic test_glitch();
`ifdef GPIO_DEBOUNCE_EN
    bus.gpio_data_in = 16'h0002;
    tick(3);
    bus.gpio_data_in = 16'h0000;
    tick(LAT + 3);
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL glitch3_stable got=%h exp=%h", bus.data_stable, 16'h0000); end
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL glitch3_status got=%h exp=%h", bus.irq_status, 16'h0000); end
    bus.gpio_data_in = 16'h0002;
    tick(4);
    bus.gpio_data_in = 16'h0000;
    tick(12);
    checks++; if (bus.irq_status !== 16'h0002) begin failures++; $display("FAIL pulse4_status got=%h exp=%h", bus.irq_status, 16'h0002); end
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL pulse4_settled got=%h exp=%h", bus.data_stable, 16'h0000); end
`else
    bus.gpio_data_in = 16'h0002;
    tick(1);
    bus.gpio_data_in = 16'h0000;
    tick(2);
    checks++; if (bus.data_stable !== 16'h0002) begin failures++; $display("FAIL glitch_pass got=%h exp=%h", bus.data_stable, 16'h0002); end
    tick(1);
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL glitch_gone got=%h exp=%h", bus.data_stable, 16'h0000); end
    checks++; if (bus.irq_status !== 16'h0002) begin failures++; $display("FAIL glitch_status got=%h exp=%h", bus.irq_status, 16'h0002); end
`endif
    clear_all();
  endtask

  task automatic test_both_edges();
    bus.irq_rise_en = 16'h0004;
    bus.irq_fall_en = 16'h0004;
    bus.gpio_data_in = 16'h0004;
    tick(LAT);
    checks++; if (bus.data_stable !== 16'h0004) begin failures++; $display("FAIL both_stable got=%h exp=%h", bus.data_stable, 16'h0004); end
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL both_status_early got=%h exp=%h", bus.irq_status, 16'h0000); end
    tick(1);
    checks++; if (bus.irq_status !== 16'h0004) begin failures++; $display("FAIL both_rise got=%h exp=%h", bus.irq_status, 16'h0004); end
    clear_all();
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL both_clear got=%h exp=%h", bus.irq_status, 16'h0000); end
    bus.gpio_data_in = 16'h0000;
    tick(LAT);
    bus.irq_clr = 16'h0004;
    tick(1);
    bus.irq_clr = 16'h0000;
    checks++; if (bus.irq_status !== 16'h0004) begin failures++; $display("FAIL set_beats_clear got=%h exp=%h", bus.irq_status, 16'h0004); end
    tick(2);
    checks++; if (bus.irq_status !== 16'h0004) begin failures++; $display("FAIL sticky got=%h exp=%h", bus.irq_status, 16'h0004); end
    clear_all();
  endtask

  task automatic test_dir_mask();
    bus.irq_rise_en = 16'hFFFF;
    bus.irq_fall_en = 16'h0000;
    bus.gpio_dir = 16'h00FF;
    bus.gpio_data_in = 16'hAAAA;
    tick(LAT + 2);
    checks++; if (bus.data_stable !== 16'hAA00) begin failures++; $display("FAIL dir_stable got=%h exp=%h", bus.data_stable, 16'hAA00); end
    checks++; if (bus.irq_status !== 16'hAA00) begin failures++; $display("FAIL dir_status got=%h exp=%h", bus.irq_status, 16'hAA00); end
    bus.gpio_dir = 16'h0000;
    tick(LEFF + 1);
    checks++; if (bus.data_stable !== 16'hAAAA) begin failures++; $display("FAIL dir_switch_stable got=%h exp=%h", bus.data_stable, 16'hAAAA); end
    checks++; if (bus.irq_status !== 16'hAA00) begin failures++; $display("FAIL dir_switch_early got=%h exp=%h", bus.irq_status, 16'hAA00); end
    tick(1);
    checks++; if (bus.irq_status !== 16'hAAAA) begin failures++; $display("FAIL dir_switch_status got=%h exp=%h", bus.irq_status, 16'hAAAA); end
  endtask

  task automatic test_async_reset();
    bus.irq_fall_en = 16'hFFFF;
    bus.gpio_data_in = 16'hFFFF;
    tick(LAT + 2);
    checks++; if (bus.irq_status !== 16'hFFFF) begin failures++; $display("FAIL pre_reset_status got=%h exp=%h", bus.irq_status, 16'hFFFF); end
    bus.gpio_data_in = 16'h0000;
    tick(SYNC + 2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL async_stable got=%h exp=%h", bus.data_stable, 16'h0000); end
    checks++; if (bus.irq_status !== 16'h0000) begin failures++; $display("FAIL async_status got=%h exp=%h", bus.irq_status, 16'h0000); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL async_irq got=%b exp=0", bus.irq); end
    bus.gpio_data_in = 16'hFFFF;
    tick(2);
    rst_n = 1'b1;
    tick(LAT - 1);
    checks++; if (bus.data_stable !== 16'h0000) begin failures++; $display("FAIL post_reset_early got=%h exp=%h", bus.data_stable, 16'h0000); end
    tick(1);
    checks++; if (bus.data_stable !== 16'hFFFF) begin failures++; $display("FAIL post_reset_stable got=%h exp=%h", bus.data_stable, 16'hFFFF); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rise();
    test_glitch();
    test_both_edges();
    test_dir_mask();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_input_irq.md
Name: gpio_input_irq

Overview:
- Downstream consumer of the combinational input-masking stage. It takes the masked input word `gpio_data_in` (output-direction bits already forced to 0) together with `gpio_dir`.
- Per-bit processing: synchronize to `clk`, debounce, detect rising/falling edges, latch sticky interrupt status.
- Drives one interrupt line to the system interrupt controller.
- Sits between the input-masking stage and the register/bus interface.

Parameters:
- `WIDTH`, 16: number of GPIO bits.
- `SYNC_STAGES`, 2: synchronizer flop depth per bit; minimum 2.
- `DEB_W`, 4: width of each per-bit debounce counter and of `deb_limit`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gpio_data_in`  in  WIDTH  masked pin values; asynchronous to `clk`.
- `gpio_dir`  in  WIDTH  1 = output, 0 = input; quasi-static, synchronous to `clk`.
- `irq_en`  in  WIDTH  per-bit interrupt enable.
- `irq_rise_en`  in  WIDTH  per-bit rising-edge select.
- `irq_fall_en`  in  WIDTH  per-bit falling-edge select.
- `irq_clr`  in  WIDTH  one-cycle write-1-to-clear pulse for `irq_status`.
- `deb_limit`  in  DEB_W  debounce threshold L, shared by all bits.
- `data_stable`  out  WIDTH  synchronized, debounced input value.
- `irq_status`  out  WIDTH  sticky per-bit interrupt flags.
- `irq`  out  1  `|(irq_status & irq_en)`.

Behaviour:
- Reset (`rst_n`=0, asynchronous, any time including mid-debounce):
  - all synchronizer flops, debounce counters, `data_stable` and `irq_status` clear to 0;
  - `irq` = 0.
- Synchronizer: `sync[i]` = `gpio_data_in[i]` delayed by `SYNC_STAGES` flops.
- Debounce, per bit:
  - if `sync != data_stable`: counter increments;
  - when the counter already equals L and the mismatch persists, `data_stable` takes `sync` and the counter returns to 0;
  - net effect: `data_stable` updates after L+1 consecutive mismatch cycles;
  - any cycle with `sync == data_stable` clears the counter (glitch rejection);
  - the counter saturates at the maximum DEB_W value and never wraps;
  - L=0: `data_stable` follows `sync` with 1 cycle delay.
- Latency: a steady level change on `gpio_data_in` reaches `data_stable` after SYNC_STAGES+L+1 rising edges. Default, L=3: 6 edges.
- Edge detect:
  - `rise = new_stable & ~old_stable`; `fall` is the inverse;
  - both are registered, so `irq_status` sets one edge after `data_stable` changes (total latency SYNC_STAGES+L+2).
- Status set condition: `irq_en[i]` & ((`rise` & `irq_rise_en`) | (`fall` & `irq_fall_en`)).
  - Bits with both select bits set trigger on both edges.
  - A set bit stays set until cleared.
- Clear: `irq_clr[i]`=1 clears the bit at the next edge. Same-cycle set and clear: set wins; the bit remains 1.
- Disabling `irq_en` does not clear `irq_status`; it only masks `irq`. `irq` is combinational from registered state, so it is glitch-free.
- Output-direction bits (`gpio_dir[i]`=1):
  - counter held at 0 and `data_stable[i]` forced to 0 without generating an edge;
  - `irq_status[i]` is never set, but retains its value and can still be cleared.
  - On a change from output to input, debounce restarts from `data_stable`=0.
- Changing `deb_limit` mid-count: the new L applies immediately. A counter already ≥ new L updates `data_stable` on the next mismatch cycle.

Optional Feature:
- Macro `GPIO_DEBOUNCE_EN`.
- Defined: debounce counters are present as described.
- Undefined:
  - no counters are synthesized;
  - `deb_limit` is ignored;
  - `data_stable` = `sync` registered once (identical to the L=0 behaviour and latency);
  - the port list is unchanged.

Decomposition:
- Shared package `gpio_pkg`:
  - `GPIO_WIDTH` = 16;
  - `GPIO_SYNC_STAGES` = 2;
  - `GPIO_DEB_W` = 4;
  - direction encoding constants `GPIO_DIR_IN` = 0 and `GPIO_DIR_OUT` = 1.
- Sub-module `gpio_debounce_bit`: synchronizer + debounce + edge detect for one bit, instantiated WIDTH times via generate.
- The top level holds the status/clear logic and the `irq` reduction.

Test Plan:
- Reset, then all-input, L=3, `irq_en`=FFFF, `irq_rise_en`=FFFF; drive `gpio_data_in`=0001 → `data_stable`=0001 after 6 edges, `irq_status`=0001 after 7, `irq`=1.
- Glitch: with L=3, pulse bit 1 high for 3 cycles then low → `data_stable[1]` stays 0 and `irq_status[1]` stays 0. A 4-cycle pulse is accepted.
- Both edges: `irq_rise_en`=`irq_fall_en`=0004, toggle bit 2 0→1, clear, then 1→0 → `irq_status`=0004 twice. Assert `irq_clr`=0004 on the same cycle as the second set → bit remains 1.
- Direction mask: `gpio_dir`=00FF, `gpio_data_in`=AAAA → `data_stable`=AA00 and `irq_status` low byte = 00. Switch `gpio_dir` to 0000 → low bits debounce from 0 and set status on their rising edges.
- Async reset asserted mid-debounce (counter=2) and with `irq_status`=FFFF → all outputs 0 immediately, no `clk` edge required. After release, a held input needs a full SYNC_STAGES+L+1 edges to reach `data_stable`.
- Compile without `GPIO_DEBOUNCE_EN`, `deb_limit`=F → a step on bit 0 reaches `data_stable` after 3 edges; a 1-cycle glitch propagates.
